// File: rtl/entropy_decode_ac_level_coefficients_pkg.sv
// Shared ProRes AC-level VLC definitions: adaptive codebook table, decoder
// FSM states and fixed widths. The encoder side reuses the same table.
package entropy_decode_ac_level_coefficients_pkg;

  localparam int MAX_ZEROS_DEF = 16;
  localparam int LEVEL_W_DEF   = 32;
  localparam int V_W           = 20;
  localparam int SFX_W         = 24;

  // Sign bit value that marks a negative level
  localparam logic SIGN_NEG = 1'b1;

  typedef enum logic [2:0] {
    ST_PREFIX = 3'd0,
    ST_SUFFIX = 3'd1,
    ST_SIGN   = 3'd2,
    ST_OUT    = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  typedef struct packed {
    logic [1:0] t;
    logic [1:0] k;
  } codebook_t;

  // Rice threshold T and exp-Golomb order k chosen by the previous level's magnitude
  function automatic codebook_t ac_level_codebook(input logic [V_W-1:0] prev);
    codebook_t cb;
    if (prev == V_W'(0)) begin
      cb.t = 2'd3;
      cb.k = 2'd2;
    end else if (prev == V_W'(1)) begin
      cb.t = 2'd2;
      cb.k = 2'd1;
    end else if (prev == V_W'(2)) begin
      cb.t = 2'd3;
      cb.k = 2'd1;
    end else if (prev == V_W'(3)) begin
      cb.t = 2'd0;
      cb.k = 2'd0;
    end else if (prev < V_W'(8)) begin
      cb.t = 2'd0;
      cb.k = 2'd1;
    end else begin
      cb.t = 2'd0;
      cb.k = 2'd2;
    end
    return cb;
  endfunction

endpackage

// File: rtl/entropy_decode_ac_level_coefficients_codebook_select.sv
// Combinational codebook lookup: previous level magnitude -> (T, k).
module entropy_decode_ac_level_coefficients_codebook_select
  import entropy_decode_ac_level_coefficients_pkg::*;
(
  input  logic [V_W-1:0] i_prev,
  output logic [1:0]     o_t,
  output logic [1:0]     o_k
);

  codebook_t w_cb;

  assign w_cb = ac_level_codebook(i_prev);
  assign o_t  = w_cb.t;
  assign o_k  = w_cb.k;

endmodule

// File: rtl/entropy_decode_ac_level_coefficients.sv
// Bit-serial ProRes AC level decoder: parses the adaptive Rice/exp-Golomb
// codeword and sign bit, then presents one signed nonzero level.
module entropy_decode_ac_level_coefficients
  import entropy_decode_ac_level_coefficients_pkg::*;
#(
  parameter int MAX_ZEROS = MAX_ZEROS_DEF,
  parameter int LEVEL_W   = LEVEL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               block_start,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               bit_ready,
  output logic               level_valid,
  output logic [LEVEL_W-1:0] level,
  input  logic               level_ready,
  output logic               error
);

  // Wide enough for the prefix count and the longest suffix length (MAX_ZEROS + 2)
  localparam int ZW = $clog2(MAX_ZEROS + 3);

  state_e             r_state;
  logic               r_bit_ready;
  logic               r_level_valid;
  logic               r_error;
  logic [LEVEL_W-1:0] r_level;
  logic [V_W-1:0]     r_prev;
  logic [V_W-1:0]     r_v;
  logic [ZW-1:0]      r_z;
  logic [ZW-1:0]      r_cnt;
  logic [SFX_W-1:0]   r_m;

  logic [1:0]         w_t;
  logic [1:0]         w_k;
  logic               w_take;
  logic               w_rice;
  logic [ZW-1:0]      w_n;
  logic [SFX_W-1:0]   w_v;
  logic [LEVEL_W-1:0] w_mag;

  // prev only changes between codewords, so (T, k) stay fixed for a whole codeword
  entropy_decode_ac_level_coefficients_codebook_select u_codebook (
    .i_prev (r_prev),
    .o_t    (w_t),
    .o_k    (w_k)
  );

  assign w_take = bit_valid & r_bit_ready;
  assign w_rice = (r_z < ZW'(w_t));
  assign w_n    = r_z - ZW'(w_t) + ZW'(w_k);
  // r_m starts at 1 and collects suffix bits, so it already equals (1 << (e+k)) | b
  assign w_v    = w_rice ? SFX_W'(r_z)
                         : (SFX_W'(w_t) + r_m) - (SFX_W'(1) << w_k);
  assign w_mag  = LEVEL_W'(w_v) + LEVEL_W'(1);

  assign bit_ready   = r_bit_ready;
  assign level_valid = r_level_valid;
  assign level       = r_level;
  assign error       = r_error;

  // Codeword parser FSM with registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_PREFIX;
      r_bit_ready   <= 1'b0;
      r_level_valid <= 1'b0;
      r_level       <= '0;
      r_error       <= 1'b0;
      r_prev        <= V_W'(1);
      r_v           <= '0;
      r_z           <= '0;
      r_cnt         <= '0;
      r_m           <= '0;
    end else if (block_start) begin
      r_state       <= ST_PREFIX;
      r_bit_ready   <= 1'b1;
      r_level_valid <= 1'b0;
      r_error       <= 1'b0;
      r_prev        <= V_W'(1);
      r_z           <= '0;
      r_cnt         <= '0;
      r_m           <= '0;
    end else begin
      case (r_state)
        ST_PREFIX: begin
          r_bit_ready <= 1'b1;
          if (w_take) begin
            if (bit_in == 1'b0) begin
              if (r_z == ZW'(MAX_ZEROS)) begin
                r_state     <= ST_ERROR;
                r_error     <= 1'b1;
                r_bit_ready <= 1'b0;
              end else begin
                r_z <= r_z + ZW'(1);
              end
            end else begin
              r_m <= SFX_W'(1);
              if (w_rice || (w_n == ZW'(0))) begin
                r_state <= ST_SIGN;
              end else begin
                r_state <= ST_SUFFIX;
                r_cnt   <= w_n;
              end
            end
          end
        end

        ST_SUFFIX: begin
          r_bit_ready <= 1'b1;
          if (w_take) begin
            r_m   <= {r_m[SFX_W-2:0], bit_in};
            r_cnt <= r_cnt - ZW'(1);
            if (r_cnt == ZW'(1)) begin
              r_state <= ST_SIGN;
            end else begin
              r_state <= ST_SUFFIX;
            end
          end
        end

        ST_SIGN: begin
          if (w_take) begin
            r_v           <= w_v[V_W-1:0];
            r_level       <= (bit_in == SIGN_NEG) ? (LEVEL_W'(0) - w_mag) : w_mag;
            r_level_valid <= 1'b1;
            r_bit_ready   <= 1'b0;
            r_state       <= ST_OUT;
          end else begin
            r_bit_ready <= 1'b1;
          end
        end

        ST_OUT: begin
          if (level_ready) begin
            r_level_valid <= 1'b0;
            r_bit_ready   <= 1'b1;
            r_prev        <= r_v;
            r_z           <= '0;
            r_state       <= ST_PREFIX;
          end else begin
            r_bit_ready <= 1'b0;
          end
        end

        ST_ERROR: begin
          r_error       <= 1'b1;
          r_bit_ready   <= 1'b0;
          r_level_valid <= 1'b0;
        end

        default: begin
          r_state       <= ST_PREFIX;
          r_bit_ready   <= 1'b0;
          r_level_valid <= 1'b0;
          r_z           <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entropy_decode_ac_level_coefficients.sv
// Self-checking bench: codewords built by a behavioural encoder model, levels
// compared in order against a queue, plus directed codebook/error/reset cases.
module tb_entropy_decode_ac_level_coefficients;

  localparam int LEVEL_W = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               block_start;
  logic               bit_valid;
  logic               bit_in;
  logic               bit_ready;
  logic               level_valid;
  logic [LEVEL_W-1:0] level;
  logic               level_ready;
  logic               error;

  int                 tests = 0;
  int                 fails = 0;
  int                 xfers = 0;
  int                 rdy_pct = 100;
  int unsigned        mprev = 1;
  logic [LEVEL_W-1:0] exp_q[$];
  bit                 held = 1'b0;
  logic [LEVEL_W-1:0] held_level;

  always #5 clk = ~clk;

  entropy_decode_ac_level_coefficients #(
    .MAX_ZEROS (16),
    .LEVEL_W   (LEVEL_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .block_start (block_start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .bit_ready   (bit_ready),
    .level_valid (level_valid),
    .level       (level),
    .level_ready (level_ready),
    .error       (error)
  );

  // Codebook as stated: (T, k) from the previous magnitude
  function automatic void model_tk(input int unsigned prev, output int t, output int k);
    if (prev == 0)      begin t = 3; k = 2; end
    else if (prev == 1) begin t = 2; k = 1; end
    else if (prev == 2) begin t = 3; k = 1; end
    else if (prev == 3) begin t = 0; k = 0; end
    else if (prev < 8)  begin t = 0; k = 1; end
    else                begin t = 0; k = 2; end
  endfunction

  // Encoder: the inverse of the decode rules, producing a '0'/'1' string
  function automatic string encode(input int unsigned prev, input int unsigned v, input bit neg);
    int t;
    int k;
    int nb;
    int unsigned m;
    string s;
    s = "";
    model_tk(prev, t, k);
    if (v < t) begin
      repeat (v) s = {s, "0"};
      s = {s, "1"};
    end else begin
      m  = v - t + (32'd1 << k);
      nb = 0;
      while ((m >> (nb + 1)) != 0) nb++;
      repeat (t + nb - k) s = {s, "0"};
      s = {s, "1"};
      for (int j = nb - 1; j >= 0; j--) begin
        if (((m >> j) & 32'd1) != 0) s = {s, "1"};
        else s = {s, "0"};
      end
    end
    if (neg) s = {s, "1"};
    else s = {s, "0"};
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic push_exp(input int lvl);
    exp_q.push_back(32'(lvl));
  endtask

  task automatic send_bits(input string s, input int stall_pct);
    int i = 0;
    int c = 0;
    int budget;
    budget = 200 * s.len() + 200;
    while (i < s.len() && c < budget) begin
      @(negedge clk);
      bit_valid   = ($urandom_range(99) >= stall_pct);
      bit_in      = (s[i] == "1");
      level_ready = ($urandom_range(99) < rdy_pct);
      if (bit_valid && bit_ready) i++;
      c++;
    end
    @(negedge clk);
    bit_valid   = 1'b0;
    level_ready = ($urandom_range(99) < rdy_pct);
    if (i < s.len()) begin
      tests++;
      fails++;
      $display("FAIL send_bits timeout: consumed %0d of %0d bits of %s", i, s.len(), s);
    end
  endtask

  task automatic drain();
    int c = 0;
    bit_valid = 1'b0;
    while (exp_q.size() > 0 && c < 500) begin
      @(negedge clk);
      level_ready = ($urandom_range(99) < rdy_pct) || (rdy_pct == 0);
      c++;
    end
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain timeout: %0d levels never delivered", exp_q.size());
    end
  endtask

  task automatic pulse_bs();
    @(negedge clk);
    block_start = 1'b1;
    bit_valid   = 1'b0;
    @(negedge clk);
    block_start = 1'b0;
    exp_q.delete();
    mprev = 1;
  endtask

  // Compare process: every delivered level against the model queue, plus hold stability
  always @(negedge clk) begin
    #1;
    if (reset || block_start) begin
      held = 1'b0;
    end else begin
      if (held) begin
        tests++;
        if (level_valid !== 1'b1 || level !== held_level) begin
          fails++;
          $display("FAIL hold: valid=%0b level=%0d, expected valid=1 level=%0d", level_valid, $signed(level), $signed(held_level));
        end
      end
      if (level_valid === 1'b1) begin
        tests++;
        if (bit_ready !== 1'b0) begin
          fails++;
          $display("FAIL ready_while_valid: bit_ready=%0b, expected 0", bit_ready);
        end
      end
      if (level_valid === 1'b1 && level_ready === 1'b1) begin
        xfers++;
        held = 1'b0;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL level: got %0d, expected no level", $signed(level));
        end else begin
          if (level !== exp_q[0]) begin
            fails++;
            $display("FAIL level: got %0d, expected %0d", $signed(level), $signed(exp_q[0]));
          end
          void'(exp_q.pop_front());
        end
      end else if (level_valid === 1'b1) begin
        held       = 1'b1;
        held_level = level;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int xb;
    reset       = 1'b1;
    block_start = 1'b0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    level_ready = 1'b1;

    // Model pins against hand-derived codewords
    chk_str("enc_prev1_v5", encode(1, 5, 1'b0), "0001010");
    chk_str("enc_prev0_v3", encode(0, 3, 1'b0), "0001000");
    chk_str("enc_prev5_v0n", encode(5, 0, 1'b1), "101");
    chk_str("enc_prev1_v0n", encode(1, 0, 1'b1), "11");

    repeat (3) @(negedge clk);
    chk("rst_bit_ready", 32'(bit_ready), 32'd0);
    chk("rst_level_valid", 32'(level_valid), 32'd0);
    chk("rst_level", level, 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_bit_ready_low", 32'(bit_ready), 32'd0);
    @(negedge clk);
    chk("rel_bit_ready_high", 32'(bit_ready), 32'd1);

    // Small levels across prev=1 then prev=0
    pulse_bs();
    push_exp(1);  send_bits("10", 0);
    push_exp(-2); send_bits("011", 0);
    drain();

    // prev=1 escape then prev=5 codebook
    pulse_bs();
    push_exp(6);  send_bits("0001010", 0);
    push_exp(-1); send_bits("101", 0);
    drain();

    // prev=0 escape, then prev=3 codebook (T=0, k=0)
    pulse_bs();
    push_exp(1); send_bits("10", 0);
    push_exp(4); send_bits("0001000", 0);
    push_exp(1); send_bits("10", 0);
    drain();

    // Prefix length: 16 zeros allowed, the 17th is a syntax error
    pulse_bs();
    send_bits("0000000000000000", 0);
    chk("z16_error", 32'(error), 32'd0);
    chk("z16_bit_ready", 32'(bit_ready), 32'd1);
    send_bits("0", 0);
    chk("z17_error", 32'(error), 32'd1);
    chk("z17_bit_ready", 32'(bit_ready), 32'd0);
    chk("z17_level_valid", 32'(level_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("err_sticky", 32'(error), 32'd1);
    pulse_bs();
    chk("bs_clears_error", 32'(error), 32'd0);
    push_exp(-1); send_bits("11", 0);
    drain();

    // Backpressure: level held while level_ready is low
    pulse_bs();
    rdy_pct = 0;
    push_exp(1);
    send_bits("10", 0);
    for (int c = 0; c < 3; c++) begin
      bit_valid   = 1'b1;
      bit_in      = 1'b1;
      level_ready = 1'b0;
      chk("bp_valid", 32'(level_valid), 32'd1);
      chk("bp_level", level, 32'd1);
      chk("bp_bit_ready", 32'(bit_ready), 32'd0);
      @(negedge clk);
    end
    xb          = xfers;
    bit_valid   = 1'b0;
    level_ready = 1'b1;
    @(negedge clk);
    level_ready = 1'b0;
    #2;
    chk("bp_single_xfer", 32'(xfers - xb), 32'd1);
    chk("bp_valid_drop", 32'(level_valid), 32'd0);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    rdy_pct = 100;

    // Reset in the middle of a suffix
    pulse_bs();
    send_bits("0001", 0);
    reset = 1'b1;
    #1;
    chk("midrst_bit_ready", 32'(bit_ready), 32'd0);
    chk("midrst_level_valid", 32'(level_valid), 32'd0);
    chk("midrst_level", level, 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    mprev = 1;
    @(negedge clk);
    push_exp(-1); send_bits("11", 0);
    drain();

    // Random codewords, first unstalled, then with stalls and backpressure
    for (int phase = 0; phase < 2; phase++) begin
      pulse_bs();
      rdy_pct = (phase == 0) ? 100 : 40;
      for (int n = 0; n < 120; n++) begin
        int unsigned v;
        bit neg;
        v   = ($urandom_range(3) == 0) ? $urandom_range(30000) : $urandom_range(12);
        neg = 1'($urandom_range(1));
        push_exp(neg ? -(int'(v) + 1) : (int'(v) + 1));
        send_bits(encode(mprev, v, neg), (phase == 0) ? 0 : 50);
        mprev = v;
      end
      drain();
    end

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_error", 32'(error), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/entropy_decode_ac_level_coefficients.md
Name: entropy_decode_ac_level_coefficients

Overview:
Bit-serial decoder for ProRes AC level codewords: the inverse of the AC-level entropy encoder. It consumes one bitstream bit per handshake and parses the adaptive Rice/Exp-Golomb codeword plus the sign bit. It then emits one signed nonzero coefficient level. It sits in the VLD path after the bitstream reader and alongside the run decoder, which supplies zero runs separately.

Parameters:
MAX_ZEROS, 16, max prefix zero count accepted before flagging a syntax error
LEVEL_W, 32, width of signed output level

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
block_start  in  1  1-cycle pulse: restart adaptation (prev := 1), abort current codeword, clear error
bit_valid  in  1  bit_in is valid this cycle
bit_in  in  1  next bitstream bit, MSB-first order
bit_ready  out  1  decoder accepts bit_in this cycle
level_valid  out  1  level holds a decoded coefficient
level  out  LEVEL_W  signed coefficient, never 0
level_ready  in  1  downstream accepts level
error  out  1  sticky syntax error (prefix > MAX_ZEROS)

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-high.
- Reset values: bit_ready=0, level_valid=0, level=0, error=0, prev=1, state=PREFIX, counters=0. bit_ready rises the first cycle after reset deassertion.
- A bit is consumed when bit_valid && bit_ready. The level transfers when level_valid && level_ready.
- Value domain: v = |level| - 1 (unsigned, 20 bits sufficient).
- Codebook selection uses prev, the v of the last decoded level in this block. It is given as (T rice threshold, k exp order):
  - prev=0: T=3, k=2
  - prev=1: T=2, k=1
  - prev=2: T=3, k=1
  - prev=3: T=0, k=0
  - prev 4..7: T=0, k=1
  - prev>=8: T=0, k=2
- The codebook is latched at codeword start.
- Code definition:
  - Count z leading zeros terminated by a 1.
  - If z<T: v=z (Rice order 0).
  - Else: e=z-T. Read e+k further bits b. m=(1<<(e+k))|b. v = T + m - 2^k.
  - Then 1 sign bit: 1 = negative. level = sign ? -(v+1) : +(v+1).
- FSM states:
  - PREFIX: bit_ready=1. A 0 increments z. If z would exceed MAX_ZEROS → ERROR. A 1 → SIGN if z<T; else → SUFFIX with cnt=e+k, or → SIGN when e+k=0.
  - SUFFIX: bit_ready=1. Shift bits into b, decrement cnt. Go to SIGN after the last bit.
  - SIGN: bit_ready=1. Capture sign, compute level, → OUT.
  - OUT: bit_ready=0, level_valid=1. Level is held stable until level_ready. On transfer: prev:=v, z:=0, → PREFIX in the same edge.
  - ERROR: error=1, bit_ready=0, level_valid=0. Held until block_start or reset.
- Latency: level_valid asserts the cycle after the sign bit is accepted. Throughput is one codeword per (bits+1) cycles.
- bit_valid low stalls any state without losing progress.
- block_start has priority over everything else. It forces PREFIX, z=0, prev=1, error=0, level_valid=0. A pending undelivered level is discarded.
- Suffix arithmetic uses 24-bit internal width. m - 2^k never underflows because m ≥ 2^k.
- Reset asserted mid-codeword returns all state to reset values immediately. No partial level is emitted.

Decomposition:
- Shared package vlc_pkg holds: codebook table function (prev → T,k), state enum, MAX_ZEROS default, sign convention constant. The encoder side reuses the same table.
- One natural sub-module: ac_level_codebook_select (prev → T,k, combinational). The FSM and datapath stay in the top.

Test Plan:
- After block_start, bits "1","0" → level=+1. Then bits "01","1" (prev=0, z=1<3) → level=-2.
- prev=1: bits "000101","0" → z=3≥T=2, e=1, b="01", m=5, v=5 → level=+6. Next bits "10","1" (prev=5: T=0, k=1) → level=-1.
- prev=0 escape: bits "000","100","0" → v=3 → level=+4. Next codeword uses prev=3 codebook (T=0, k=0): "1","0" → +1.
- 17 consecutive zeros → error=1 on the 17th zero, bit_ready=0. block_start → error=0, prev=1, decoding resumes.
- Hold level_ready=0 for 3 cycles with a level pending → level stable, bit_ready=0, no bits consumed. Release → a single transfer. Toggle bit_valid randomly inside a codeword → same levels as the unstalled run.
- Assert reset during SUFFIX → all outputs return to reset values next sample. After release, "1","1" decodes to -1 (prev=1).
